// File: rtl/alu_mul_sequencer_if.sv
// Request/result and ALU drive bundle for the shift-add multiply sequencer.
// The slave modport is the sequencer's view; master is the requester/ALU side.
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [31:0]      product;
  logic             prod_zero;
  logic             alu_fault;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             alu_sel;
  logic [4:0]       alu_op;
  logic [31:0]      alu_result;
  logic             alu_carry;

  modport slave (
    input  start, op_a, op_b, alu_result, alu_carry,
    output busy, done, product, prod_zero, alu_fault,
           alu_a, alu_b, alu_sel, alu_op
  );

  modport master (
    output start, op_a, op_b, alu_result, alu_carry,
    input  busy, done, product, prod_zero, alu_fault,
           alu_a, alu_b, alu_sel, alu_op
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned multiplier that borrows the execute-stage ALU,
// sequencing ADD and shift-left-by-one operations (shift-add algorithm).
module alu_mul_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter logic [4:0]  ALUOP_PASS = 5'b00000,
  parameter logic [4:0]  ALUOP_ADD  = 5'b00001,
  parameter logic [4:0]  ALUOP_SHL  = 5'b01000
) (
  input  logic                clk,
  input  logic                rst,
  alu_mul_sequencer_if.slave  bus
);

  localparam int unsigned PW = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;
  logic             r_prod_zero;
  logic             r_fault;

  logic [PW-1:0]    w_alu_a;
  logic [PW-1:0]    w_alu_b;
  logic [4:0]       w_alu_op;

  // Sequencer state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_product   <= '0;
      r_prod_zero <= 1'b1;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand  <= PW'(bus.op_a);
            r_mplier <= bus.op_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_fault  <= 1'b0;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          // Early exit once no multiplier bits remain
          if ((r_mplier == '0) || (r_count == CW'(WIDTH))) begin
            r_state <= S_DONE;
          end else if (r_mplier[0]) begin
            r_state <= S_ADD;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_ADD: begin
          r_acc   <= bus.alu_result;
          r_fault <= r_fault | bus.alu_carry;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_mcand  <= bus.alu_result;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          r_state  <= S_EVAL;
        end
        S_DONE: begin
          r_product   <= r_acc;
          r_prod_zero <= (r_acc == '0);
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore ALU drive, decoded from state only
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = ALUOP_PASS;
    case (r_state)
      S_ADD: begin
        w_alu_a  = r_acc;
        w_alu_b  = r_mcand;
        w_alu_op = ALUOP_ADD;
      end
      S_SHIFT: begin
        w_alu_a  = r_mcand;
        w_alu_b  = PW'(1);
        w_alu_op = ALUOP_SHL;
      end
      default: begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = ALUOP_PASS;
      end
    endcase
  end

  assign bus.alu_a     = w_alu_a;
  assign bus.alu_b     = w_alu_b;
  assign bus.alu_op    = w_alu_op;
  assign bus.alu_sel   = 1'b0;

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  // acc is final in DONE, so expose it there so product is valid alongside done
  assign bus.product   = (r_state == S_DONE) ? r_acc : r_product;
  assign bus.prod_zero = r_prod_zero;
  assign bus.alu_fault = r_fault;

endmodule
